// File: rtl/issue.sv
// rtl/issue.sv - in-order issue/rename stage: instruction queue, decode, ROB tag allocation and dispatch
module issue #(
    parameter int IQ_DEPTH  = 8,
    parameter int ROB_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instr,
    output logic        fetch_ready,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic [2:0]  rs_ready,
    output logic        disp_valid,
    output logic [1:0]  disp_unit,
    output logic [31:0] disp_instr,
    output logic [2:0]  disp_tag,
    output logic [4:0]  disp_rd,
    output logic        disp_src1_ready,
    output logic [31:0] disp_src1_val,
    output logic [2:0]  disp_src1_tag,
    output logic        disp_src2_ready,
    output logic [31:0] disp_src2_val,
    output logic [2:0]  disp_src2_tag,
    output logic [11:0] disp_imm,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_tag,
    input  logic [31:0] cdb_value,
    input  logic        commit_valid,
    input  logic [4:0]  commit_rd,
    input  logic [2:0]  commit_tag,
    output logic        illegal
);

    localparam int IQ_AW = $clog2(IQ_DEPTH);
    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam logic [IQ_AW:0]   IQ_FULL  = (IQ_AW+1)'(IQ_DEPTH);
    localparam logic [TAG_W:0]   ROB_FULL = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [IQ_AW-1:0] IQ_PTR1  = (IQ_AW)'(1);
    localparam logic [IQ_AW:0]   IQ_CNT1  = (IQ_AW+1)'(1);
    localparam logic [TAG_W-1:0] ROB_PTR1 = (TAG_W)'(1);
    localparam logic [TAG_W:0]   ROB_CNT1 = (TAG_W+1)'(1);

    typedef struct packed {
        logic             ready;
        logic [31:0]      val;
        logic [TAG_W-1:0] tag;
    } operand_t;

    logic [31:0]      iq_mem [IQ_DEPTH];
    logic [IQ_AW-1:0] iq_head, iq_tail;
    logic [IQ_AW:0]   iq_count;
    logic [TAG_W-1:0] rob_tail;
    logic [TAG_W:0]   rob_count;
    logic [31:0]      reg_valid;
    logic [TAG_W-1:0] rename [32];

    logic [31:0] head_instr;
    logic        iq_empty, legal, is_load, unit_ready, push, pop, fire;
    logic [1:0]  unit;
    logic [4:0]  rs1, rs2, rd;
    operand_t    src1, src2;

    // A register waiting on a tag can be satisfied by the CDB in the same cycle.
    function automatic operand_t resolve(input logic [4:0] r, input logic valid,
                                         input logic [TAG_W-1:0] tag, input logic [31:0] rdata,
                                         input logic bus_valid, input logic [TAG_W-1:0] bus_tag,
                                         input logic [31:0] bus_value);
        operand_t op;
        op = '0;
        if (r == 5'd0) begin
            op.ready = 1'b1;
        end else if (valid) begin
            op.ready = 1'b1;
            op.val   = rdata;
        end else if (bus_valid && bus_tag == tag) begin
            op.ready = 1'b1;
            op.val   = bus_value;
        end else begin
            op.tag = tag;
        end
        return op;
    endfunction

    assign head_instr = iq_mem[iq_head];
    assign iq_empty   = (iq_count == '0);
    assign rs1        = head_instr[19:15];
    assign rs2        = head_instr[24:20];
    assign rd         = head_instr[11:7];

    always_comb begin
        legal   = 1'b0;
        unit    = 2'd0;
        is_load = 1'b0;
        if (head_instr[6:0] == 7'b0110011) begin
            if ((head_instr[31:25] == 7'b0000000 || head_instr[31:25] == 7'b0100000)
                && head_instr[14:12] == 3'b000) begin
                legal = 1'b1;
                unit  = 2'd0;
            end else if (head_instr[31:25] == 7'b0000001
                         && (head_instr[14:12] == 3'b000 || head_instr[14:12] == 3'b100)) begin
                legal = 1'b1;
                unit  = 2'd1;
            end
        end else if (head_instr[6:0] == 7'b0000011 && head_instr[14:12] == 3'b010) begin
            legal   = 1'b1;
            unit    = 2'd2;
            is_load = 1'b1;
        end
    end

    always_comb begin
        case (unit)
            2'd0:    unit_ready = rs_ready[0];
            2'd1:    unit_ready = rs_ready[1];
            default: unit_ready = rs_ready[2];
        endcase
    end

    always_comb begin
        src1 = resolve(rs1, reg_valid[rs1], rename[rs1], rf_rdata1, cdb_valid, cdb_tag, cdb_value);
        src2 = resolve(rs2, reg_valid[rs2], rename[rs2], rf_rdata2, cdb_valid, cdb_tag, cdb_value);
        if (is_load) begin
            src2 = '0;
            src2.ready = 1'b1;
        end
    end

    assign fetch_ready = (iq_count != IQ_FULL);
    assign push        = fetch_valid && fetch_ready;
    assign disp_valid  = !iq_empty && legal && (rob_count != ROB_FULL);
    assign fire        = disp_valid && unit_ready;
    assign illegal     = !iq_empty && !legal;
    assign pop         = fire || illegal;

    assign rf_raddr1       = rs1;
    assign rf_raddr2       = rs2;
    assign disp_unit       = unit;
    assign disp_instr      = head_instr;
    assign disp_tag        = rob_tail;
    assign disp_rd         = rd;
    assign disp_src1_ready = src1.ready;
    assign disp_src1_val   = src1.val;
    assign disp_src1_tag   = src1.tag;
    assign disp_src2_ready = src2.ready;
    assign disp_src2_val   = src2.val;
    assign disp_src2_tag   = src2.tag;
    assign disp_imm        = is_load ? head_instr[31:20] : 12'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            iq_mem[iq_tail] <= fetch_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iq_head   <= '0;
            iq_tail   <= '0;
            iq_count  <= '0;
            rob_tail  <= '0;
            rob_count <= '0;
            reg_valid <= '1;
            for (int i = 0; i < 32; i++) begin
                rename[i] <= '0;
            end
        end else begin
            if (push) iq_tail <= iq_tail + IQ_PTR1;
            if (pop)  iq_head <= iq_head + IQ_PTR1;
            case ({push, pop})
                2'b10:   iq_count <= iq_count + IQ_CNT1;
                2'b01:   iq_count <= iq_count - IQ_CNT1;
                default: iq_count <= iq_count;
            endcase
            if (fire) rob_tail <= rob_tail + ROB_PTR1;
            case ({fire, commit_valid})
                2'b10:   rob_count <= rob_count + ROB_CNT1;
                2'b01:   rob_count <= rob_count - ROB_CNT1;
                default: rob_count <= rob_count;
            endcase
            if (commit_valid && rename[commit_rd] == commit_tag) begin
                reg_valid[commit_rd] <= 1'b1;
            end
            // Placed after the commit update so a same-cycle rename of the register wins.
            if (fire && rd != 5'd0) begin
                reg_valid[rd] <= 1'b0;
                rename[rd]    <= rob_tail;
            end
        end
    end

endmodule

// File: tb/tb_issue.sv
// tb/tb_issue.sv - directed self-checking bench for the issue stage
module tb_issue;

    logic        clk, rst;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [2:0]  rs_ready;
    logic        disp_valid;
    logic [1:0]  disp_unit;
    logic [31:0] disp_instr;
    logic [2:0]  disp_tag;
    logic [4:0]  disp_rd;
    logic        disp_src1_ready, disp_src2_ready;
    logic [31:0] disp_src1_val, disp_src2_val;
    logic [2:0]  disp_src1_tag, disp_src2_tag;
    logic [11:0] disp_imm;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [2:0]  commit_tag;
    logic        illegal;

    logic [31:0] rf [32];
    int passed = 0;
    int total  = 0;

    issue dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_ready(fetch_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rs_ready(rs_ready), .disp_valid(disp_valid), .disp_unit(disp_unit), .disp_instr(disp_instr),
        .disp_tag(disp_tag), .disp_rd(disp_rd),
        .disp_src1_ready(disp_src1_ready), .disp_src1_val(disp_src1_val), .disp_src1_tag(disp_src1_tag),
        .disp_src2_ready(disp_src2_ready), .disp_src2_val(disp_src2_val), .disp_src2_tag(disp_src2_tag),
        .disp_imm(disp_imm), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag), .illegal(illegal)
    );

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return r_type(7'b0000000, 3'b000, rd, rs1, rs2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr);
        fetch_instr = instr;
        fetch_valid = 1'b1;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic fire();
        rs_ready = 3'b111;
        step();
        rs_ready = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_valid = 1'b0; fetch_instr = '0; rs_ready = 3'b000;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_tag = '0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (disp_valid !== 1'b0) $display("FAIL reset_disp_valid: got %0d want 0", disp_valid); else passed++;
        total++; if (fetch_ready !== 1'b1) $display("FAIL reset_fetch_ready: got %0d want 1", fetch_ready); else passed++;
        total++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %0d want 0", illegal); else passed++;
    endtask

    task automatic test_add();
        do_reset();
        push(add_i(5'd3, 5'd1, 5'd2));
        total++; if (disp_valid !== 1'b1) $display("FAIL add_valid: got %0d want 1", disp_valid); else passed++;
        total++; if (disp_unit !== 2'd0) $display("FAIL add_unit: got %0d want 0", disp_unit); else passed++;
        total++; if (disp_tag !== 3'd0) $display("FAIL add_tag: got %0d want 0", disp_tag); else passed++;
        total++; if ({disp_src1_ready, disp_src1_val} !== {1'b1, 32'd12})
            $display("FAIL add_src1: got %0d/%0d want 1/12", disp_src1_ready, disp_src1_val); else passed++;
        total++; if ({disp_src2_ready, disp_src2_val} !== {1'b1, 32'd16})
            $display("FAIL add_src2: got %0d/%0d want 1/16", disp_src2_ready, disp_src2_val); else passed++;
        total++; if ({disp_rd, disp_imm} !== {5'd3, 12'd0})
            $display("FAIL add_rd_imm: got %0d/%0d want 3/0", disp_rd, disp_imm); else passed++;
        fire();
        total++; if (disp_valid !== 1'b0) $display("FAIL add_popped: got %0d want 0", disp_valid); else passed++;
    endtask

    task automatic test_dependency();
        push(r_type(7'b0100000, 3'b000, 5'd4, 5'd3, 5'd1));
        total++; if ({disp_src1_ready, disp_src1_tag, disp_src1_val} !== {1'b0, 3'd0, 32'd0})
            $display("FAIL dep_src1_wait: got %0d/%0d/%0d want 0/0/0", disp_src1_ready, disp_src1_tag, disp_src1_val); else passed++;
        total++; if ({disp_src2_ready, disp_src2_val} !== {1'b1, 32'd12})
            $display("FAIL dep_src2: got %0d/%0d want 1/12", disp_src2_ready, disp_src2_val); else passed++;
        total++; if (disp_tag !== 3'd1) $display("FAIL dep_tag: got %0d want 1", disp_tag); else passed++;
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'd28;
        #1;
        total++; if ({disp_src1_ready, disp_src1_val} !== {1'b1, 32'd28})
            $display("FAIL dep_cdb_bypass: got %0d/%0d want 1/28", disp_src1_ready, disp_src1_val); else passed++;
        cdb_valid = 1'b0;
    endtask

    task automatic test_rob_full();
        do_reset();
        rs_ready = 3'b111;
        fetch_instr = r_type(7'b0000001, 3'b000, 5'd7, 5'd1, 5'd2);
        fetch_valid = 1'b1;
        for (int i = 0; i < 9; i++) step();
        fetch_valid = 1'b0;
        total++; if (disp_valid !== 1'b0) $display("FAIL robfull_hold: got %0d want 0", disp_valid); else passed++;
        total++; if (disp_unit !== 2'd1) $display("FAIL robfull_unit: got %0d want 1", disp_unit); else passed++;
        commit_valid = 1'b1; commit_rd = 5'd7; commit_tag = 3'd0;
        step();
        commit_valid = 1'b0;
        total++; if ({disp_valid, disp_tag} !== {1'b1, 3'd0})
            $display("FAIL robfull_wrap: got %0d/%0d want 1/0", disp_valid, disp_tag); else passed++;
        rs_ready = 3'b000;
    endtask

    task automatic test_iq_full();
        do_reset();
        fetch_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch_instr = add_i(5'(8 + i), 5'd1, 5'd2);
            step();
        end
        total++; if (fetch_ready !== 1'b0) $display("FAIL iqfull_ready: got %0d want 0", fetch_ready); else passed++;
        fetch_instr = add_i(5'd16, 5'd1, 5'd2);
        step();
        fetch_instr = add_i(5'd20, 5'd1, 5'd2);
        rs_ready = 3'b001;
        step();
        fetch_valid = 1'b0;
        total++; if (fetch_ready !== 1'b1) $display("FAIL iqfull_after_pop: got %0d want 1", fetch_ready); else passed++;
        for (int i = 0; i < 7; i++) begin
            total++; if ({disp_valid, disp_rd, disp_tag} !== {1'b1, 5'(9 + i), 3'(1 + i)})
                $display("FAIL iqfull_drain%0d: got %0d/%0d/%0d want 1/%0d/%0d", i, disp_valid, disp_rd, disp_tag, 9 + i, 1 + i);
            else passed++;
            step();
        end
        rs_ready = 3'b000;
        commit_valid = 1'b1; commit_rd = 5'd8; commit_tag = 3'd0;
        step();
        commit_valid = 1'b0;
        total++; if (disp_valid !== 1'b0) $display("FAIL iqfull_refused_push: got %0d want 0", disp_valid); else passed++;
    endtask

    task automatic test_load_illegal();
        do_reset();
        push({12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011});
        total++; if ({disp_valid, disp_unit, disp_imm, disp_rd} !== {1'b1, 2'd2, 12'd8, 5'd5})
            $display("FAIL load_decode: got %0d/%0d/%0d/%0d want 1/2/8/5", disp_valid, disp_unit, disp_imm, disp_rd); else passed++;
        total++; if ({disp_src1_ready, disp_src1_val, disp_src2_ready, disp_src2_val} !== {1'b1, 32'd12, 1'b1, 32'd0})
            $display("FAIL load_srcs: got %0d/%0d/%0d/%0d want 1/12/1/0", disp_src1_ready, disp_src1_val, disp_src2_ready, disp_src2_val); else passed++;
        rs_ready = 3'b100;
        step();
        rs_ready = 3'b000;
        total++; if (disp_valid !== 1'b0) $display("FAIL load_fired: got %0d want 0", disp_valid); else passed++;
        push(32'hFFFF_FFFF);
        total++; if ({illegal, disp_valid} !== {1'b1, 1'b0})
            $display("FAIL illegal_pulse: got %0d/%0d want 1/0", illegal, disp_valid); else passed++;
        step();
        total++; if (illegal !== 1'b0) $display("FAIL illegal_once: got %0d want 0", illegal); else passed++;
        push(add_i(5'd3, 5'd1, 5'd2));
        total++; if (disp_tag !== 3'd1) $display("FAIL illegal_no_tag: got %0d want 1", disp_tag); else passed++;
    endtask

    task automatic test_stale_commit();
        do_reset();
        push(add_i(5'd3, 5'd1, 5'd2));
        fire();
        push(add_i(5'd3, 5'd1, 5'd2));
        fire();
        commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 3'd0;
        step();
        commit_valid = 1'b0;
        push(add_i(5'd4, 5'd3, 5'd0));
        total++; if ({disp_src1_ready, disp_src1_tag, disp_tag} !== {1'b0, 3'd1, 3'd2})
            $display("FAIL stale_commit: got %0d/%0d/%0d want 0/1/2", disp_src1_ready, disp_src1_tag, disp_tag); else passed++;
        commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 3'd1;
        step();
        commit_valid = 1'b0;
        total++; if ({disp_src1_ready, disp_src1_val} !== {1'b1, 32'd103})
            $display("FAIL current_commit: got %0d/%0d want 1/103", disp_src1_ready, disp_src1_val); else passed++;
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 32'd55;
        commit_valid = 1'b1; commit_rd = 5'd4; commit_tag = 3'd0;
        fire();
        cdb_valid = 1'b0; commit_valid = 1'b0;
        push(add_i(5'd6, 5'd4, 5'd0));
        total++; if ({disp_src1_ready, disp_src1_tag} !== {1'b0, 3'd2})
            $display("FAIL rename_beats_commit: got %0d/%0d want 0/2", disp_src1_ready, disp_src1_tag); else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(add_i(5'd3, 5'd1, 5'd2));
        fire();
        push(r_type(7'b0100000, 3'b000, 5'd4, 5'd3, 5'd1));
        total++; if (disp_valid !== 1'b1) $display("FAIL midrst_pre: got %0d want 1", disp_valid); else passed++;
        rst = 1'b1;
        #1;
        total++; if ({disp_valid, fetch_ready} !== 2'b01)
            $display("FAIL midrst_clear: got %0d/%0d want 0/1", disp_valid, fetch_ready); else passed++;
        step();
        rst = 1'b0;
        push(r_type(7'b0100000, 3'b000, 5'd4, 5'd3, 5'd1));
        total++; if ({disp_src1_ready, disp_src1_val, disp_tag} !== {1'b1, 32'd103, 3'd0})
            $display("FAIL midrst_regs_valid: got %0d/%0d/%0d want 1/103/0", disp_src1_ready, disp_src1_val, disp_tag); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(100 + i);
        rf[0] = 32'd0;
        rf[1] = 32'd12;
        rf[2] = 32'd16;
        test_reset();
        test_add();
        test_dependency();
        test_rob_full();
        test_iq_full();
        test_load_illegal();
        test_stale_commit();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/issue.md
Name: issue

Overview:
- In-order issue/rename stage of the 32-bit Tomasulo core.
- Buffers fetched RV32 instructions in an 8-entry instruction queue (IQ) and decodes the IQ head.
- Allocates a reorder-buffer (ROB) tag for the head instruction, renames its destination register, and dispatches it with resolved operands to one of three reservation-station groups: add/sub, mul/div, or load.
- Sits between fetch and the reservation stations; the register file, ROB storage and commit logic are external to this block.

Parameters:
- IQ_DEPTH, 8, instruction-queue entries (power of two).
- ROB_DEPTH, 8, ROB entries; tag width is log2(ROB_DEPTH) = 3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  fetch_instr is offered this cycle.
- fetch_instr  in  32  raw instruction word.
- fetch_ready  out  1  IQ can accept; equals (IQ count < IQ_DEPTH).
- rf_raddr1  out  5  register-file read address, driven as head instr[19:15].
- rf_raddr2  out  5  register-file read address, driven as head instr[24:20].
- rf_rdata1  in  32  combinational read data for rf_raddr1.
- rf_rdata2  in  32  combinational read data for rf_raddr2.
- rs_ready  in  3  free slot available: bit0 add/sub, bit1 mul/div, bit2 load.
- disp_valid  out  1  a legal head instruction can be dispatched.
- disp_unit  out  2  target group: 0 add/sub, 1 mul/div, 2 load.
- disp_instr  out  32  head instruction word.
- disp_tag  out  3  ROB tag allocated to the instruction (current ROB tail).
- disp_rd  out  5  destination register, instr[11:7].
- disp_src1_ready  out  1  1 = disp_src1_val holds the value; 0 = wait on disp_src1_tag.
- disp_src1_val  out  32  source-1 value.
- disp_src1_tag  out  3  ROB tag producing source 1.
- disp_src2_ready  out  1  as for source 1.
- disp_src2_val  out  32  as for source 1.
- disp_src2_tag  out  3  as for source 1.
- disp_imm  out  12  load offset, instr[31:20]; 0 for other ops.
- cdb_valid  in  1  common-data-bus broadcast valid.
- cdb_tag  in  3  tag of the broadcast result.
- cdb_value  in  32  broadcast result value.
- commit_valid  in  1  ROB retired its head entry this cycle.
- commit_rd  in  5  destination register of the retired entry.
- commit_tag  in  3  tag of the retired entry.
- illegal  out  1  one-cycle pulse when an unsupported head instruction is discarded.

Behaviour:
- Reset: IQ empty, head/tail = 0; ROB tail = 0, ROB count = 0; every register valid, every rename tag = 0; illegal = 0. disp_valid = 0 and fetch_ready = 1 follow combinationally.
- IQ push:
  - Push when fetch_valid && fetch_ready; pointers wrap modulo 8.
  - When the IQ is full, pushes are refused even if a pop happens in the same cycle.
- Decode of the head instruction (RV32 encodings):
  - Opcode 0110011 with funct7 0000000 or 0100000, funct3 000: add/sub, unit 0.
  - Opcode 0110011 with funct7 0000001 and funct3 000 or 100: mul/div, unit 1.
  - Opcode 0000011 with funct3 010: load, unit 2. Source 2 is forced to ready = 1, value = 0.
  - Any other encoding is illegal.
- disp_valid = IQ not empty && legal && ROB count < ROB_DEPTH. It does not depend on rs_ready.
- Fire = disp_valid && rs_ready[disp_unit]. At most one instruction fires per cycle. On fire:
  - Pop the IQ.
  - ROB tail += 1 (wraps modulo 8).
  - ROB count += 1.
  - If rd != 0: mark rd invalid and set rename[rd] = disp_tag.
- Illegal head (IQ not empty): popped in one cycle without allocating a ROB tag; illegal pulses for that cycle.
- Operand resolution, independently for each source register r:
  - r == 0 → ready, value 0.
  - Register valid → ready, value = rf_rdata.
  - Register invalid and cdb_valid with cdb_tag == rename[r] → ready, value = cdb_value (same-cycle bypass).
  - Otherwise → not ready, tag = rename[r], value = 0.
- Commit:
  - When commit_valid and rename[commit_rd] == commit_tag, set register commit_rd valid.
  - If an instruction firing in the same cycle renames the same register, the rename wins and the register stays invalid with the new tag.
  - ROB count -= 1 on commit_valid. Fire and commit in the same cycle leave the count unchanged.
- ROB full (count == 8): disp_valid = 0 and the head stalls; fetch continues until the IQ is full.
- Reset asserted mid-operation clears all state immediately and discards in-flight IQ contents.

Test Plan:
- Reset; register file preloaded x1=12, x2=16; push add x3,x1,x2 with all rs_ready=1 → next cycle disp_valid=1, unit=0, tag=0, src1 12 ready, src2 16 ready. After the edge, x3 is invalid with rename tag 0.
- Push add x3,x1,x2 then sub x4,x3,x1 → second dispatch has src1_ready=0, src1_tag=0, src2=12 ready, tag=1. Repeat with cdb_valid, cdb_tag=0, cdb_value=28 in the dispatch cycle → src1_ready=1, value 28.
- Issue 8 instructions with no commits → ninth holds with disp_valid=0. One commit_valid → ninth fires with tag 0 (wrap-around).
- Push 9 instructions with rs_ready=0 → fetch_ready drops after 8. Raise rs_ready[0] → one instruction pops per cycle.
- Load lw x5,8(x1) → unit=2, disp_imm=8, src1 12 ready, src2_ready=1. Illegal word 0xFFFFFFFF → illegal pulses for one cycle, ROB tail unchanged.
- commit_valid for x3 with a stale tag after x3 was re-renamed → x3 remains invalid. Assert rst mid-stream → IQ empty, all registers valid.
